// File: rtl/regfile_writeback_ctrl.sv
// Register-file write master: queues writeback requests in a small FIFO, issues them
// in order onto the registered write port and flags read-after-write hazards.
module regfile_writeback_ctrl #(
   parameter int DEPTH = 4,
   parameter int DW    = 32,
   parameter int AW    = 5
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Flush,
   input  logic                     In_Valid,
   output logic                     In_Ready,
   input  logic [AW-1:0]            In_Reg_Num,
   input  logic [DW-1:0]            In_Data,
   input  logic                     Wb_Enable,
   output logic                     RegWrite,
   output logic [AW-1:0]            Write_Reg_Num,
   output logic [DW-1:0]            Write_Data,
   input  logic [AW-1:0]            Read_Reg_Num1,
   input  logic [AW-1:0]            Read_Reg_Num2,
   output logic                     Hazard_1,
   output logic                     Hazard_2,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Empty,
   output logic                     Full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] r_reg_mem  [DEPTH];
   logic [DW-1:0] r_data_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_reg_write;
   logic [AW-1:0] r_wr_num;
   logic [DW-1:0] r_wr_data;

   logic          w_full;
   logic          w_empty;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;
   logic          w_hit1;
   logic          w_hit2;
   logic [PW-1:0] w_idx;

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign In_Ready = !w_full && !Flush && !Reset;
   assign w_accept = In_Valid && In_Ready;
   // Writes to register 0 are consumed without occupying a slot.
   assign w_push   = w_accept && (In_Reg_Num != '0);
   assign w_pop    = !w_empty && Wb_Enable;

   assign RegWrite      = r_reg_write;
   assign Write_Reg_Num = r_wr_num;
   assign Write_Data    = r_wr_data;
   assign Count         = r_count;
   assign Empty         = w_empty;
   assign Full          = w_full;

   // Storage needs no reset: occupancy alone decides which slots are live.
   always_ff @(posedge Clk) begin
      if (w_push) begin
         r_reg_mem[r_wr_ptr]  <= In_Reg_Num;
         r_data_mem[r_wr_ptr] <= In_Data;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_reg_write <= 1'b0;
         r_wr_num    <= '0;
         r_wr_data   <= '0;
      end else if (Flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_reg_write <= 1'b0;
      end else begin
         r_reg_write <= w_pop;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_wr_num  <= r_reg_mem[r_rd_ptr];
            r_wr_data <= r_data_mem[r_rd_ptr];
            r_rd_ptr  <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // A read collides with any live slot or with the write currently on the port.
   always_comb begin
      w_hit1 = 1'b0;
      w_hit2 = 1'b0;
      w_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_rd_ptr + PW'(i);
         if (CW'(i) < r_count) begin
            if (r_reg_mem[w_idx] == Read_Reg_Num1) w_hit1 = 1'b1;
            if (r_reg_mem[w_idx] == Read_Reg_Num2) w_hit2 = 1'b1;
         end
      end
      if (r_reg_write && (r_wr_num == Read_Reg_Num1)) w_hit1 = 1'b1;
      if (r_reg_write && (r_wr_num == Read_Reg_Num2)) w_hit2 = 1'b1;
      Hazard_1 = w_hit1 && (Read_Reg_Num1 != '0);
      Hazard_2 = w_hit2 && (Read_Reg_Num2 != '0);
   end
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Bench for regfile_writeback_ctrl: directed scenarios with literal expectations plus
// a randomized run compared every cycle against a queue-based model.
module tb_regfile_writeback_ctrl;
   localparam int DEPTH = 4;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          Clk;
   logic          Reset;
   logic          Flush;
   logic          In_Valid;
   logic          In_Ready;
   logic [AW-1:0] In_Reg_Num;
   logic [DW-1:0] In_Data;
   logic          Wb_Enable;
   logic          RegWrite;
   logic [AW-1:0] Write_Reg_Num;
   logic [DW-1:0] Write_Data;
   logic [AW-1:0] Read_Reg_Num1;
   logic [AW-1:0] Read_Reg_Num2;
   logic          Hazard_1;
   logic          Hazard_2;
   logic [CW-1:0] Count;
   logic          Empty;
   logic          Full;

   regfile_writeback_ctrl #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
      .Clk(Clk), .Reset(Reset), .Flush(Flush),
      .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Reg_Num(In_Reg_Num), .In_Data(In_Data),
      .Wb_Enable(Wb_Enable), .RegWrite(RegWrite), .Write_Reg_Num(Write_Reg_Num),
      .Write_Data(Write_Data), .Read_Reg_Num1(Read_Reg_Num1), .Read_Reg_Num2(Read_Reg_Num2),
      .Hazard_1(Hazard_1), .Hazard_2(Hazard_2), .Count(Count), .Empty(Empty), .Full(Full)
   );

   // clock
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int passed = 0;
   int total  = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      else passed++;
   endtask

   // model: pending writes as plain queues, plus the last issued write
   logic [AW-1:0] q_reg[$];
   logic [DW-1:0] q_data[$];
   logic          m_rw   = 1'b0;
   logic [AW-1:0] m_num  = '0;
   logic [DW-1:0] m_data = '0;

   function automatic logic m_hazard(input logic [AW-1:0] num);
      logic hit;
      hit = m_rw && (m_num == num);
      foreach (q_reg[k]) if (q_reg[k] == num) hit = 1'b1;
      return hit && (num != '0);
   endfunction

   always @(posedge Clk) begin
      if (Reset) begin
         q_reg.delete(); q_data.delete();
         m_rw = 1'b0; m_num = '0; m_data = '0;
      end else if (Flush) begin
         q_reg.delete(); q_data.delete();
         m_rw = 1'b0;
      end else begin
         bit can_take;
         can_take = In_Valid && (q_reg.size() < DEPTH);
         if (Wb_Enable && q_reg.size() > 0) begin
            m_rw = 1'b1;
            m_num = q_reg.pop_front();
            m_data = q_data.pop_front();
         end else begin
            m_rw = 1'b0;
         end
         if (can_take && In_Reg_Num != '0) begin
            q_reg.push_back(In_Reg_Num);
            q_data.push_back(In_Data);
         end
      end
   end

   // per-cycle compare against the model
   always @(negedge Clk) begin
      if (chk_en) begin
         chk("in_ready",  In_Ready, (q_reg.size() < DEPTH) && !Flush && !Reset);
         chk("regwrite",  RegWrite, m_rw);
         chk("wr_num",    Write_Reg_Num, m_num);
         chk("wr_data",   Write_Data, m_data);
         chk("count",     Count, q_reg.size());
         chk("empty",     Empty, q_reg.size() == 0);
         chk("full",      Full, q_reg.size() == DEPTH);
         chk("hazard_1",  Hazard_1, m_hazard(Read_Reg_Num1));
         chk("hazard_2",  Hazard_2, m_hazard(Read_Reg_Num2));
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive_push(input logic [AW-1:0] r, input logic [DW-1:0] d);
      In_Valid = 1'b1; In_Reg_Num = r; In_Data = d;
   endtask

   initial begin
      Reset = 1'b1; Flush = 1'b0; In_Valid = 1'b0; In_Reg_Num = '0; In_Data = '0;
      Wb_Enable = 1'b0; Read_Reg_Num1 = '0; Read_Reg_Num2 = '0;
      tick();
      chk_en = 1'b1;
      tick();

      // reset values, then single write
      chk("rst_in_ready", In_Ready, 1'b0);
      chk("rst_regwrite", RegWrite, 1'b0);
      chk("rst_wr_num",   Write_Reg_Num, 0);
      chk("rst_wr_data",  Write_Data, 0);
      chk("rst_count",    Count, 0);
      chk("rst_empty",    Empty, 1'b1);
      chk("rst_full",     Full, 1'b0);
      chk("rst_haz1",     Hazard_1, 1'b0);
      Reset = 1'b0;
      #1 chk("post_rst_ready", In_Ready, 1'b1);
      drive_push(5'd6, 32'h18);
      tick();
      chk("t1_rw_n",    RegWrite, 1'b0);
      chk("t1_count_n", Count, 1);
      In_Valid = 1'b0; Wb_Enable = 1'b1;
      tick();
      chk("t1_rw",   RegWrite, 1'b1);
      chk("t1_num",  Write_Reg_Num, 6);
      chk("t1_data", Write_Data, 32'h18);
      tick();
      chk("t1_rw_off",  RegWrite, 1'b0);
      chk("t1_hold",    Write_Data, 32'h18);

      // fill and backpressure
      Wb_Enable = 1'b0;
      for (int r = 1; r <= 4; r++) begin
         drive_push(AW'(r), DW'(r * 32'h11));
         tick();
      end
      chk("fill_full",  Full, 1'b1);
      chk("fill_count", Count, 4);
      drive_push(5'd5, 32'h55);
      #1 chk("fill_ready", In_Ready, 1'b0);
      tick();
      chk("fill_no_acc", Count, 4);
      In_Valid = 1'b0; Wb_Enable = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("drain_rw",    RegWrite, 1'b1);
         chk("drain_num",   Write_Reg_Num, k);
         chk("drain_count", Count, 4 - k);
      end
      chk("drain_empty", Empty, 1'b1);
      tick();
      chk("drain_done", RegWrite, 1'b0);

      // same-register ordering
      Wb_Enable = 1'b0;
      drive_push(5'd9, 32'hAAAA); tick();
      drive_push(5'd9, 32'h5555); tick();
      In_Valid = 1'b0; Wb_Enable = 1'b1;
      tick();
      chk("ord_first",  Write_Data, 32'hAAAA);
      tick();
      chk("ord_second", Write_Data, 32'h5555);
      chk("ord_rw",     RegWrite, 1'b1);
      tick();
      chk("ord_final",  Write_Data, 32'h5555);
      chk("ord_rw_off", RegWrite, 1'b0);

      // hazard
      Wb_Enable = 1'b0; Read_Reg_Num1 = 5'd7; Read_Reg_Num2 = 5'd0;
      drive_push(5'd7, 32'h77); tick();
      In_Valid = 1'b0;
      chk("haz_1", Hazard_1, 1'b1);
      chk("haz_2", Hazard_2, 1'b0);
      tick();
      chk("haz_hold", Hazard_1, 1'b1);
      Wb_Enable = 1'b1;
      tick();
      chk("haz_rw",     RegWrite, 1'b1);
      chk("haz_rw_h1",  Hazard_1, 1'b1);
      tick();
      chk("haz_clear",  Hazard_1, 1'b0);

      // register 0 discard
      Read_Reg_Num1 = 5'd0;
      drive_push(5'd0, 32'hFFFF);
      #1 chk("r0_ready", In_Ready, 1'b1);
      tick();
      In_Valid = 1'b0;
      chk("r0_count", Count, 0);
      chk("r0_haz",   Hazard_1, 1'b0);
      tick();
      chk("r0_no_rw", RegWrite, 1'b0);

      // flush mid-stream, then continuous stream across the pointer wrap
      Wb_Enable = 1'b0;
      for (int r = 10; r <= 12; r++) begin
         drive_push(AW'(r), DW'(r)); tick();
      end
      In_Valid = 1'b0; Flush = 1'b1;
      tick();
      chk("fl_count", Count, 0);
      chk("fl_rw",    RegWrite, 1'b0);
      Flush = 1'b0; Wb_Enable = 1'b1;
      tick();
      chk("fl_stale", RegWrite, 1'b0);
      for (int i = 0; i < 10; i++) begin
         drive_push(AW'(i + 1), 32'h100 + DW'(i));
         tick();
         if (i > 0) begin
            chk("wrap_rw",   RegWrite, 1'b1);
            chk("wrap_data", Write_Data, 32'h100 + DW'(i - 1));
         end
         chk("wrap_count", Count, 1);
      end
      In_Valid = 1'b0;
      tick();
      chk("wrap_last", Write_Data, 32'h109);
      tick();
      chk("wrap_end", RegWrite, 1'b0);

      // randomized traffic against the model
      for (int c = 0; c < 2000; c++) begin
         In_Valid      = ($urandom_range(0, 9) < 7);
         In_Reg_Num    = AW'($urandom_range(0, 7));
         In_Data       = $urandom;
         Wb_Enable     = ($urandom_range(0, 9) < 5);
         Flush         = ($urandom_range(0, 99) < 3);
         Reset         = ($urandom_range(0, 199) < 1);
         Read_Reg_Num1 = AW'($urandom_range(0, 7));
         Read_Reg_Num2 = AW'($urandom_range(0, 7));
         tick();
      end
      In_Valid = 1'b0; Flush = 1'b0; Reset = 1'b0;
      tick();
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/regfile_writeback_ctrl.md
# regfile_writeback_ctrl

Write-side master for the 32x32 register file: buffers register writeback requests from the execute/memory stages in a small FIFO and issues them in order onto the register file write port (`RegWrite`/`Write_Reg_Num`/`Write_Data`), at most one per cycle. It also reports read-after-write hazards for the two operand register numbers being read this cycle, so the decode stage can stall until pending writes land.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DW`, 32: data width.
- `AW`, 5: register number width.

Ports:
- `Clk`, in, 1: clock; all state changes on the rising edge.
- `Reset`, in, 1: **synchronous, active-high** reset.
- `Flush`, in, 1: synchronous discard of all pending writes.
- `In_Valid`, in, 1: a write request is presented.
- `In_Ready`, out, 1: the block can accept a request.
- `In_Reg_Num`, in, AW: destination register.
- `In_Data`, in, DW: data to write.
- `Wb_Enable`, in, 1: the core permits a write to issue this cycle.
- `RegWrite`, out, 1: registered write strobe to the register file.
- `Write_Reg_Num`, out, AW: registered write address.
- `Write_Data`, out, DW: registered write data.
- `Read_Reg_Num1`, in, AW: first operand register being read.
- `Read_Reg_Num2`, in, AW: second operand register being read.
- `Hazard_1`, out, 1: a write to `Read_Reg_Num1` is pending.
- `Hazard_2`, out, 1: a write to `Read_Reg_Num2` is pending.
- `Count`, out, $clog2(DEPTH)+1: number of FIFO entries.
- `Empty`, out, 1: `Count`==0.
- `Full`, out, 1: `Count`==DEPTH.

## Operation
- Accept rule: a request is accepted at an edge where `In_Valid`&&`In_Ready`.
- `In_Ready` = !`Full` && !`Flush` && !`Reset`. It is combinational and does not look ahead at a same-cycle pop.
- Register 0 is a discard target. An accepted request with `In_Reg_Num`==0 is consumed but not enqueued, and `Count` does not change.
- FIFO: circular, with write and read pointers of log2(DEPTH) bits that wrap modulo DEPTH. `Count` tracks occupancy separately, so full and empty are unambiguous.
- Issue: at each edge, if !`Empty` && `Wb_Enable`, the head entry is popped into the output registers and `RegWrite`<=1. Otherwise `RegWrite`<=0. `Write_Reg_Num` and `Write_Data` hold their last values when `RegWrite`=0.
- Simultaneous push and pop: the entry is written at the tail and the head is popped, so `Count` is unchanged. When the FIFO is empty, a push and a pop cannot occur at the same edge (there is no bypass).
- Ordering is strict FIFO. Back-to-back writes to the same register issue in arrival order, so the last one wins.
- Hazard detection, combinational. `Hazard_n`=1 when `Read_Reg_Num_n`≠0 and it matches either:
  - any occupied FIFO entry, or
  - `Write_Reg_Num` while `RegWrite`=1.
- Flush: at the edge, both pointers and `Count` go to 0 and `RegWrite`<=0. A write already on the output in the flush cycle completes, because the register file samples it during that cycle.
- Reset has the same effect as Flush and also clears `Write_Reg_Num` and `Write_Data` to 0.

## Timing
- Reset values:
  - `RegWrite`=0, `Write_Reg_Num`=0, `Write_Data`=0.
  - `Count`=0, `Empty`=1, `Full`=0.
  - `Hazard_1`=`Hazard_2`=0.
  - `In_Ready`=0 while `Reset` is high, and 1 in the first cycle after it falls.
- Latency: a request accepted at edge N is popped at edge N+1 at the earliest, so `RegWrite`=1 during cycle N+1→N+2.
- Throughput: one write per cycle sustained with `Wb_Enable`=1. A full FIFO drains DEPTH entries in DEPTH cycles.
- `Wb_Enable` low: no pop. Entries remain visible to hazard detection.
- Reset or Flush mid-stream: pending entries are lost and no `RegWrite` pulse follows the edge.
- `Reset` takes precedence over `Flush`, and `Flush` takes precedence over push and pop.

## Test plan
- Reset then single write:
  - Stimulus: `Reset` 2 cycles; then accept (reg 6, 0x00000018) at edge N.
  - Response: `RegWrite`=1 for exactly one cycle after edge N+1, with `Write_Reg_Num`=6 and `Write_Data`=0x18. All outputs hold their reset values before the accept.
- Fill and backpressure (DEPTH=4, `Wb_Enable`=0):
  - Stimulus: push regs 1,2,3,4; present reg 5; then raise `Wb_Enable`.
  - Response: after 4 accepts, `Full`=1, `In_Ready`=0, and reg 5 is not accepted. Writes then issue as 1,2,3,4 on consecutive cycles, and `Count` steps down to 0 with `Empty`=1.
- Same-register ordering:
  - Stimulus: push (reg 9, 0xAAAA) then (reg 9, 0x5555).
  - Response: two `RegWrite` pulses in that order, so the final value written is 0x5555.
- Hazard:
  - Stimulus: reg 7 pending with `Read_Reg_Num1`=7 and `Read_Reg_Num2`=0.
  - Response: `Hazard_1`=1 and `Hazard_2`=0. `Hazard_1` stays 1 during the `RegWrite` cycle for reg 7 and drops to 0 on the next cycle.
- Register 0:
  - Stimulus: push (reg 0, 0xFFFF).
  - Response: accepted, `Count` stays 0, no `RegWrite`, and no hazard for reg 0.
- Flush mid-stream and wrap-around:
  - Stimulus: 3 entries pending, assert `Flush` for 1 cycle, then push and pop 10 entries continuously.
  - Response: `Count`=0 and no stale writes after the flush. The 10 entries issue in order across the pointer wrap with no loss or duplication.
